fetch_seq: RTL and testbench

//  Parametrised fetch/sequencing unit for the 9-bit-ISA core. It replaces the bare PC + PC_LUT pair.

---
 rtl/fetch_seq.sv | 110 +++++++++++
 tb/tb_fetch_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Fetch/sequencing unit for the 9-bit-ISA core: program counter, writable branch table,
// absolute/relative jumps, stall/halt, and a 4-phase req/done run handshake with the host.
module fetch_seq #(
    parameter int             D          = 10,
    parameter int             B          = 5,
    parameter int             OFF_W      = 5,
    parameter int             CNT_W      = 16,
    parameter logic [D-1:0]   START_ADDR = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req,
    input  logic             i_halt,
    input  logic             i_stall,
    input  logic             i_absjump_en,
    input  logic [B-1:0]     i_branch_tag,
    input  logic             i_reljump_en,
    input  logic [OFF_W-1:0] i_rel_off,
    input  logic             i_tbl_we,
    input  logic [B-1:0]     i_tbl_waddr,
    input  logic [D-1:0]     i_tbl_wdata,
    output logic [D-1:0]     o_prog_ctr,
    output logic             o_instr_valid,
    output logic             o_done,
    output logic [CNT_W-1:0] o_run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [D-1:0]     r_pc;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [D-1:0]     r_tbl [2**B];

    logic [D-1:0]     w_rel_ext;
    logic [D-1:0]     w_pc_inc;
    logic [D-1:0]     w_pc_rel;
    logic [D-1:0]     w_tbl_rd;
    logic [CNT_W-1:0] w_cnt_next;

    // Offset is sign-extended so negative offsets wrap the PC modulo 2**D.
    assign w_rel_ext  = {{(D-OFF_W){i_rel_off[OFF_W-1]}}, i_rel_off};
    assign w_pc_inc   = r_pc + {{(D-1){1'b0}}, 1'b1};
    assign w_pc_rel   = r_pc + w_rel_ext;
    assign w_tbl_rd   = r_tbl[i_branch_tag];
    assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            for (int i = 0; i < 2**B; i++) begin
                r_tbl[i] <= '0;
            end
        end else begin
            // Table read is combinational, so a same-cycle jump sees the pre-write entry.
            if (i_tbl_we) begin
                r_tbl[i_tbl_waddr] <= i_tbl_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_state <= S_RUN;
                        r_pc    <= START_ADDR;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (i_halt) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (i_stall) begin
                        r_pc <= r_pc;
                    end else if (i_absjump_en) begin
                        r_pc <= w_tbl_rd;
                    end else if (i_reljump_en) begin
                        r_pc <= w_pc_rel;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                S_DONE: begin
                    // Acknowledge held until the host drops req, completing the 4-phase cycle.
                    if (!i_req) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_prog_ctr    = r_pc;
    assign o_done        = r_done;
    assign o_run_cycles  = r_cnt;
    assign o_instr_valid = (r_state == S_RUN) && !i_stall;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed testbench for fetch_seq: reset, sequencing, table/relative jumps, priority,
// handshake and counter saturation (on a second narrow-counter instance).
module tb_fetch_seq;

    logic       clk;
    logic       reset;
    logic       req;
    logic       halt;
    logic       stall;
    logic       absJumpEn;
    logic [4:0] branchTag;
    logic       relJumpEn;
    logic [4:0] relOff;
    logic       tblWe;
    logic [4:0] tblWaddr;
    logic [9:0] tblWdata;

    logic [9:0]  progCtr;
    logic        instrValid;
    logic        done;
    logic [15:0] runCycles;

    logic [9:0]  satProgCtr;
    logic        satInstrValid;
    logic        satDone;
    logic [2:0]  satRunCycles;

    int numCompared;
    int numMismatched;

    fetch_seq dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req        (req),
        .i_halt       (halt),
        .i_stall      (stall),
        .i_absjump_en (absJumpEn),
        .i_branch_tag (branchTag),
        .i_reljump_en (relJumpEn),
        .i_rel_off    (relOff),
        .i_tbl_we     (tblWe),
        .i_tbl_waddr  (tblWaddr),
        .i_tbl_wdata  (tblWdata),
        .o_prog_ctr   (progCtr),
        .o_instr_valid(instrValid),
        .o_done       (done),
        .o_run_cycles (runCycles)
    );

    fetch_seq #(.CNT_W(3)) dutSat (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req        (req),
        .i_halt       (halt),
        .i_stall      (stall),
        .i_absjump_en (absJumpEn),
        .i_branch_tag (branchTag),
        .i_reljump_en (relJumpEn),
        .i_rel_off    (relOff),
        .i_tbl_we     (tblWe),
        .i_tbl_waddr  (tblWaddr),
        .i_tbl_wdata  (tblWdata),
        .o_prog_ctr   (satProgCtr),
        .o_instr_valid(satInstrValid),
        .o_done       (satDone),
        .o_run_cycles (satRunCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req       = 1'b0;
        halt      = 1'b0;
        stall     = 1'b0;
        absJumpEn = 1'b0;
        branchTag = '0;
        relJumpEn = 1'b0;
        relOff    = '0;
        tblWe     = 1'b0;
        tblWaddr  = '0;
        tblWdata  = '0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic finishRun();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        req  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clearInputs();
        reset    = 1'b1;
        tblWe    = 1'b1;
        tblWaddr = 5'd7;
        tblWdata = 10'h155;
        tick();
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL reset_pc: got %h want %h", progCtr, 10'h000); end
        numCompared++;
        if (done !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        numCompared++;
        if (instrValid !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", instrValid); end
        numCompared++;
        if (runCycles !== 16'd0) begin numMismatched++; $display("[TB] FAIL reset_cycles: got %0d want 0", runCycles); end
        reset    = 1'b0;
        tblWaddr = 5'd1;
        tblWdata = 10'h05D;
        req      = 1'b1;
        tick();
        tblWe     = 1'b0;
        absJumpEn = 1'b1;
        branchTag = 5'd1;
        tick();
        numCompared++;
        if (progCtr !== 10'h05D) begin numMismatched++; $display("[TB] FAIL midrun_pc: got %h want %h", progCtr, 10'h05D); end
        absJumpEn = 1'b0;
        reset     = 1'b1;
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL midrun_reset_pc: got %h want %h", progCtr, 10'h000); end
        numCompared++;
        if (done !== 1'b0 || instrValid !== 1'b0) begin numMismatched++; $display("[TB] FAIL midrun_reset_flags: got done=%b valid=%b want 0/0", done, instrValid); end
        numCompared++;
        if (runCycles !== 16'd0) begin numMismatched++; $display("[TB] FAIL midrun_reset_cycles: got %0d want 0", runCycles); end
        reset = 1'b0;
        tick();
        absJumpEn = 1'b1;
        branchTag = 5'd1;
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL table_cleared_1: got %h want %h", progCtr, 10'h000); end
        branchTag = 5'd7;
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL table_cleared_7: got %h want %h", progCtr, 10'h000); end
        absJumpEn = 1'b0;
        finishRun();
    endtask

    task automatic test_wrap();
        doReset();
        tblWe    = 1'b1;
        tblWaddr = 5'd2;
        tblWdata = 10'h3FE;
        req      = 1'b1;
        tick();
        tblWe     = 1'b0;
        absJumpEn = 1'b1;
        branchTag = 5'd2;
        tick();
        numCompared++;
        if (progCtr !== 10'h3FE) begin numMismatched++; $display("[TB] FAIL wrap_jump: got %h want %h", progCtr, 10'h3FE); end
        absJumpEn = 1'b0;
        tick();
        numCompared++;
        if (progCtr !== 10'h3FF) begin numMismatched++; $display("[TB] FAIL wrap_seq1: got %h want %h", progCtr, 10'h3FF); end
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL wrap_seq2: got %h want %h", progCtr, 10'h000); end
        finishRun();
    endtask

    task automatic test_table_jump();
        doReset();
        req = 1'b1;
        tick();
        tblWe    = 1'b1;
        tblWaddr = 5'd3;
        tblWdata = 10'h120;
        tick();
        tblWe     = 1'b0;
        absJumpEn = 1'b1;
        branchTag = 5'd3;
        tick();
        numCompared++;
        if (progCtr !== 10'h120) begin numMismatched++; $display("[TB] FAIL tbl_jump: got %h want %h", progCtr, 10'h120); end
        tblWe     = 1'b1;
        tblWaddr  = 5'd4;
        tblWdata  = 10'h200;
        branchTag = 5'd4;
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL tbl_same_cycle_old: got %h want %h", progCtr, 10'h000); end
        tblWe = 1'b0;
        tick();
        numCompared++;
        if (progCtr !== 10'h200) begin numMismatched++; $display("[TB] FAIL tbl_after_write: got %h want %h", progCtr, 10'h200); end
        absJumpEn = 1'b0;
        finishRun();
    endtask

    task automatic test_relative();
        doReset();
        tblWe    = 1'b1;
        tblWaddr = 5'd5;
        tblWdata = 10'h010;
        req      = 1'b1;
        tick();
        tblWe     = 1'b0;
        absJumpEn = 1'b1;
        branchTag = 5'd5;
        tick();
        absJumpEn = 1'b0;
        relJumpEn = 1'b1;
        relOff    = 5'b11100;
        tick();
        numCompared++;
        if (progCtr !== 10'h00C) begin numMismatched++; $display("[TB] FAIL rel_minus4: got %h want %h", progCtr, 10'h00C); end
        relOff = 5'b10100;
        tick();
        numCompared++;
        if (progCtr !== 10'h000) begin numMismatched++; $display("[TB] FAIL rel_minus12: got %h want %h", progCtr, 10'h000); end
        relOff = 5'b11111;
        tick();
        numCompared++;
        if (progCtr !== 10'h3FF) begin numMismatched++; $display("[TB] FAIL rel_minus1_wrap: got %h want %h", progCtr, 10'h3FF); end
        relOff = 5'b01111;
        tick();
        numCompared++;
        if (progCtr !== 10'h00E) begin numMismatched++; $display("[TB] FAIL rel_plus15_wrap: got %h want %h", progCtr, 10'h00E); end
        absJumpEn = 1'b1;
        relOff    = 5'b00001;
        tick();
        numCompared++;
        if (progCtr !== 10'h010) begin numMismatched++; $display("[TB] FAIL abs_over_rel: got %h want %h", progCtr, 10'h010); end
        absJumpEn = 1'b0;
        relJumpEn = 1'b0;
        finishRun();
    endtask

    task automatic test_priority();
        doReset();
        tblWe    = 1'b1;
        tblWaddr = 5'd6;
        tblWdata = 10'h2AA;
        req      = 1'b1;
        tick();
        tblWe = 1'b0;
        tick();
        tick();
        stall     = 1'b1;
        absJumpEn = 1'b1;
        branchTag = 5'd6;
        #1;
        numCompared++;
        if (instrValid !== 1'b0) begin numMismatched++; $display("[TB] FAIL stall_valid: got %b want 0", instrValid); end
        tick();
        numCompared++;
        if (progCtr !== 10'h002) begin numMismatched++; $display("[TB] FAIL stall_over_abs: got %h want %h", progCtr, 10'h002); end
        halt = 1'b1;
        tick();
        numCompared++;
        if (progCtr !== 10'h002) begin numMismatched++; $display("[TB] FAIL halt_pc: got %h want %h", progCtr, 10'h002); end
        numCompared++;
        if (done !== 1'b1) begin numMismatched++; $display("[TB] FAIL halt_done: got %b want 1", done); end
        numCompared++;
        if (runCycles !== 16'd4) begin numMismatched++; $display("[TB] FAIL halt_cycles: got %0d want 4", runCycles); end
        halt      = 1'b0;
        stall     = 1'b0;
        absJumpEn = 1'b0;
        tick();
        numCompared++;
        if (done !== 1'b1 || progCtr !== 10'h002) begin numMismatched++; $display("[TB] FAIL done_hold: got done=%b pc=%h want 1/%h", done, progCtr, 10'h002); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_handshake();
        doReset();
        req = 1'b1;
        tick();
        numCompared++;
        if (instrValid !== 1'b1) begin numMismatched++; $display("[TB] FAIL hs_run_valid: got %b want 1", instrValid); end
        tick();
        tick();
        req = 1'b0;
        tick();
        numCompared++;
        if (progCtr !== 10'h003 || instrValid !== 1'b1) begin numMismatched++; $display("[TB] FAIL hs_no_abort: got pc=%h valid=%b want %h/1", progCtr, instrValid, 10'h003); end
        halt = 1'b1;
        req  = 1'b1;
        tick();
        halt = 1'b0;
        numCompared++;
        if (done !== 1'b1) begin numMismatched++; $display("[TB] FAIL hs_done: got %b want 1", done); end
        numCompared++;
        if (runCycles !== 16'd4) begin numMismatched++; $display("[TB] FAIL hs_cycles: got %0d want 4", runCycles); end
        tick();
        numCompared++;
        if (done !== 1'b1) begin numMismatched++; $display("[TB] FAIL hs_done_held: got %b want 1", done); end
        req = 1'b0;
        tick();
        numCompared++;
        if (done !== 1'b0 || instrValid !== 1'b0) begin numMismatched++; $display("[TB] FAIL hs_idle: got done=%b valid=%b want 0/0", done, instrValid); end
        numCompared++;
        if (runCycles !== 16'd4) begin numMismatched++; $display("[TB] FAIL hs_cycles_kept: got %0d want 4", runCycles); end
        req = 1'b1;
        tick();
        numCompared++;
        if (progCtr !== 10'h000 || runCycles !== 16'd0) begin numMismatched++; $display("[TB] FAIL hs_restart: got pc=%h cycles=%0d want 000/0", progCtr, runCycles); end
        numCompared++;
        if (instrValid !== 1'b1 || done !== 1'b0) begin numMismatched++; $display("[TB] FAIL hs_restart_flags: got valid=%b done=%b want 1/0", instrValid, done); end
        finishRun();
    endtask

    task automatic test_saturate();
        doReset();
        req = 1'b1;
        tick();
        repeat (10) tick();
        finishRun();
        numCompared++;
        if (runCycles !== 16'd11) begin numMismatched++; $display("[TB] FAIL sat_wide: got %0d want 11", runCycles); end
        numCompared++;
        if (satRunCycles !== 3'd7) begin numMismatched++; $display("[TB] FAIL sat_narrow: got %0d want 7", satRunCycles); end
        req = 1'b1;
        tick();
        numCompared++;
        if (satRunCycles !== 3'd0) begin numMismatched++; $display("[TB] FAIL sat_restart: got %0d want 0", satRunCycles); end
        finishRun();
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_wrap();
        test_table_jump();
        test_relative();
        test_priority();
        test_handshake();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
